// File: rtl/pal_pkg.sv
// Shared PAL definitions: loader FSM states and crosspoint index helpers
// used by the loader, the fabric and the bench.
package pal_pkg;

   localparam int PAL_N_INPUTS   = 4;
   localparam int PAL_N_PRODUCTS = 8;
   localparam int PAL_N_OUTPUTS  = 4;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      LOAD   = 2'd1,
      COMMIT = 2'd2
   } pal_state_e;

   // AND-plane bit for product p, input i, polarity pol (1 = complement)
   function automatic int and_idx(input int p, input int i, input int pol);
      return p * 2 * PAL_N_INPUTS + 2 * i + pol;
   endfunction

   // OR-plane bit for output o, product p
   function automatic int or_idx(input int o, input int p);
      return o * PAL_N_PRODUCTS + p;
   endfunction

endpackage

// File: rtl/pal_cfg_shreg.sv
// Shadow shift register: serial in at the MSB, shifting toward bit 0,
// so the first bit received ends at q[0] after a full load.
module pal_cfg_shreg
   import pal_pkg::*;
#(
   parameter int W = 96
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         clr,
   input  logic         shift,
   input  logic         din,
   output logic [W-1:0] q
);

   // clear wins over shift so a restart drops the same-cycle bit
   always_ff @(posedge clk) begin
      if (!rst_n)     q <= '0;
      else if (clr)   q <= '0;
      else if (shift) q <= {din, q[W-1:1]};
   end

endmodule

// File: rtl/pal_cfg_loader.sv
// Serial configuration loader: assembles a stream in a shadow register and
// commits it atomically to the active AND/OR plane configuration.
module pal_cfg_loader
   import pal_pkg::*;
#(
   parameter int N_INPUTS   = 4,
   parameter int N_PRODUCTS = 8,
   parameter int N_OUTPUTS  = 4,
   localparam int AND_BITS  = 2 * N_INPUTS * N_PRODUCTS,
   localparam int OR_BITS   = N_PRODUCTS * N_OUTPUTS,
   localparam int CFG_BITS  = AND_BITS + OR_BITS,
   localparam int CW        = $clog2(CFG_BITS + 1)
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                cfg_start,
   input  logic                cfg_bit,
   input  logic                cfg_valid,
   output logic                cfg_ready,
   input  logic                cfg_abort,
   output logic                busy,
   output logic                done,
   output logic                loaded,
   output logic [CW-1:0]       bit_count,
   output logic [AND_BITS-1:0] cfg_and,
   output logic [OR_BITS-1:0]  cfg_or
);

   pal_state_e          state, state_nxt;
   logic                clr, accept, commit;
   logic [CFG_BITS-1:0] shadow;

   pal_cfg_shreg #(.W(CFG_BITS)) u_shreg (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (clr),
      .shift (accept),
      .din   (cfg_bit),
      .q     (shadow)
   );

   // state register
   always_ff @(posedge clk) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   // next state and control; abort beats start beats valid
   always_comb begin
      state_nxt = state;
      clr       = 1'b0;
      accept    = 1'b0;
      commit    = 1'b0;
      unique case (state)
         IDLE: begin
            if (cfg_start) begin
               state_nxt = LOAD;
               clr       = 1'b1;
            end
         end
         LOAD: begin
            if (cfg_abort) begin
               state_nxt = IDLE;
               clr       = 1'b1;
            end else if (cfg_start) begin
               clr = 1'b1;
            end else if (cfg_valid) begin
               accept = 1'b1;
               if (bit_count == CW'(CFG_BITS - 1)) state_nxt = COMMIT;
            end
         end
         COMMIT: begin
            commit    = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign cfg_ready = (state == LOAD);
   assign busy      = (state != IDLE);
   assign done      = (state == COMMIT);

   // accepted-bit counter, saturating at a full stream
   always_ff @(posedge clk) begin
      if (!rst_n)                                        bit_count <= '0;
      else if (clr)                                      bit_count <= '0;
      else if (accept && bit_count != CW'(CFG_BITS))     bit_count <= bit_count + 1'b1;
   end

   // active config only ever changes as a whole in COMMIT
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cfg_and <= '0;
         cfg_or  <= '0;
         loaded  <= 1'b0;
      end else if (commit) begin
         {cfg_or, cfg_and} <= shadow;
         loaded            <= 1'b1;
      end
   end

endmodule

// File: tb/tb_pal_cfg_loader.sv
// Directed self-checking bench for pal_cfg_loader.
module tb_pal_cfg_loader;
   import pal_pkg::*;

   localparam int AND_BITS = 64;
   localparam int OR_BITS  = 32;
   localparam int CFG_BITS = 96;
   localparam int CW       = 7;

   logic                clk = 1'b0;
   logic                rst_n, cfg_start, cfg_bit, cfg_valid, cfg_abort;
   logic                cfg_ready, busy, done, loaded;
   logic [CW-1:0]       bit_count;
   logic [AND_BITS-1:0] cfg_and;
   logic [OR_BITS-1:0]  cfg_or;

   int errors = 0;
   int checks = 0;

   pal_cfg_loader dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .cfg_start (cfg_start),
      .cfg_bit   (cfg_bit),
      .cfg_valid (cfg_valid),
      .cfg_ready (cfg_ready),
      .cfg_abort (cfg_abort),
      .busy      (busy),
      .done      (done),
      .loaded    (loaded),
      .bit_count (bit_count),
      .cfg_and   (cfg_and),
      .cfg_or    (cfg_or)
   );

   always #5 clk = ~clk;

   // stream patterns, bit k is the k-th bit sent (k from 0)
   function automatic logic pbit(input int sel, input int k);
      case (sel)
         0:       return (k % 3) == 0;
         1:       return (k % 5) == 1;
         default: return (k % 2) == 0;
      endcase
   endfunction

   function automatic logic [AND_BITS-1:0] exp_and(input int sel);
      logic [AND_BITS-1:0] v;
      for (int k = 0; k < AND_BITS; k++) v[k] = pbit(sel, k);
      return v;
   endfunction

   function automatic logic [OR_BITS-1:0] exp_or(input int sel);
      logic [OR_BITS-1:0] v;
      for (int k = 0; k < OR_BITS; k++) v[k] = pbit(sel, AND_BITS + k);
      return v;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic start_load();
      cfg_start = 1'b1;
      tick();
      cfg_start = 1'b0;
   endtask

   // send bits [first, first+n) of pattern sel; gap inserts an idle cycle between bits
   task automatic send_bits(input int sel, input int first, input int n, input bit gap);
      for (int k = first; k < first + n; k++) begin
         cfg_valid = 1'b1;
         cfg_bit   = pbit(sel, k);
         tick();
         cfg_valid = 1'b0;
         cfg_bit   = 1'b0;
         if (gap && k < first + n - 1) tick();
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;
      checks++; if (cfg_and !== '0) begin errors++; $display("FAIL reset_cfg_and got %h want 0", cfg_and); end
      checks++; if (cfg_or !== '0) begin errors++; $display("FAIL reset_cfg_or got %h want 0", cfg_or); end
      checks++; if (busy !== 1'b0 || loaded !== 1'b0 || cfg_ready !== 1'b0 || done !== 1'b0)
         begin errors++; $display("FAIL reset_flags busy=%b loaded=%b ready=%b done=%b want 0", busy, loaded, cfg_ready, done); end
      checks++; if (bit_count !== '0) begin errors++; $display("FAIL reset_count got %0d want 0", bit_count); end
   endtask

   task automatic test_full_load();
      start_load();
      checks++; if (busy !== 1'b1 || cfg_ready !== 1'b1) begin errors++; $display("FAIL full_enter_load busy=%b ready=%b want 1 1", busy, cfg_ready); end
      send_bits(0, 0, CFG_BITS, 1'b0);
      // in COMMIT: done high, old config still active
      checks++; if (done !== 1'b1) begin errors++; $display("FAIL full_done_pulse got %b want 1", done); end
      checks++; if (cfg_ready !== 1'b0) begin errors++; $display("FAIL full_ready_commit got %b want 0", cfg_ready); end
      checks++; if (cfg_and !== '0) begin errors++; $display("FAIL full_no_early_commit got %h want 0", cfg_and); end
      checks++; if (bit_count !== CW'(96)) begin errors++; $display("FAIL full_count got %0d want 96", bit_count); end
      cfg_start = 1'b1;  // ignored in COMMIT
      tick();
      cfg_start = 1'b0;
      checks++; if (done !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL full_after_commit done=%b busy=%b want 0 0", done, busy); end
      checks++; if (cfg_and !== exp_and(0)) begin errors++; $display("FAIL full_cfg_and got %h want %h", cfg_and, exp_and(0)); end
      checks++; if (cfg_or !== exp_or(0)) begin errors++; $display("FAIL full_cfg_or got %h want %h", cfg_or, exp_or(0)); end
      checks++; if (cfg_and[and_idx(0,0,0)] !== 1'b1 || cfg_and[and_idx(0,0,1)] !== 1'b0 || cfg_or[or_idx(0,0)] !== 1'b0)
         begin errors++; $display("FAIL full_spot_bits and0=%b and1=%b or0=%b want 1 0 0", cfg_and[0], cfg_and[1], cfg_or[0]); end
      checks++; if (loaded !== 1'b1) begin errors++; $display("FAIL full_loaded got %b want 1", loaded); end
   endtask

   task automatic test_gappy_valid();
      // first put a different config in place so the gappy load must visibly change it
      start_load();
      send_bits(1, 0, CFG_BITS, 1'b0);
      tick();
      checks++; if (cfg_and !== exp_and(1) || cfg_or !== exp_or(1)) begin errors++; $display("FAIL gap_pre_cfg got %h/%h want %h/%h", cfg_or, cfg_and, exp_or(1), exp_and(1)); end
      start_load();
      send_bits(0, 0, CFG_BITS, 1'b1);
      checks++; if (done !== 1'b1 || cfg_and !== exp_and(1)) begin errors++; $display("FAIL gap_commit_cycle done=%b and=%h want 1 %h", done, cfg_and, exp_and(1)); end
      tick();
      checks++; if (cfg_and !== exp_and(0) || cfg_or !== exp_or(0)) begin errors++; $display("FAIL gap_cfg got %h/%h want %h/%h", cfg_or, cfg_and, exp_or(0), exp_and(0)); end
   endtask

   task automatic test_abort();
      start_load();
      send_bits(2, 0, 50, 1'b0);
      checks++; if (bit_count !== CW'(50)) begin errors++; $display("FAIL abort_count_before got %0d want 50", bit_count); end
      cfg_abort = 1'b1;
      cfg_start = 1'b1;  // abort outranks start
      cfg_valid = 1'b1;
      tick();
      cfg_abort = 1'b0;
      cfg_start = 1'b0;
      cfg_valid = 1'b0;
      checks++; if (busy !== 1'b0 || bit_count !== '0) begin errors++; $display("FAIL abort_state busy=%b count=%0d want 0 0", busy, bit_count); end
      checks++; if (cfg_and !== exp_and(0) || cfg_or !== exp_or(0) || loaded !== 1'b1)
         begin errors++; $display("FAIL abort_cfg_kept got %h/%h loaded=%b want %h/%h 1", cfg_or, cfg_and, loaded, exp_or(0), exp_and(0)); end
      cfg_abort = 1'b1;  // no effect in IDLE
      tick();
      cfg_abort = 1'b0;
      checks++; if (busy !== 1'b0 || cfg_and !== exp_and(0)) begin errors++; $display("FAIL abort_idle busy=%b and=%h", busy, cfg_and); end
   endtask

   task automatic test_restart();
      start_load();
      send_bits(2, 0, 40, 1'b0);
      cfg_start = 1'b1;
      cfg_valid = 1'b1;
      cfg_bit   = 1'b1;
      tick();
      cfg_start = 1'b0;
      cfg_valid = 1'b0;
      checks++; if (bit_count !== '0 || busy !== 1'b1 || cfg_ready !== 1'b1)
         begin errors++; $display("FAIL restart_state count=%0d busy=%b ready=%b want 0 1 1", bit_count, busy, cfg_ready); end
      send_bits(1, 0, CFG_BITS - 1, 1'b0);
      checks++; if (done !== 1'b0 || bit_count !== CW'(95)) begin errors++; $display("FAIL restart_count95 done=%b count=%0d want 0 95", done, bit_count); end
      send_bits(1, CFG_BITS - 1, 1, 1'b0);
      checks++; if (done !== 1'b1) begin errors++; $display("FAIL restart_done got %b want 1", done); end
      tick();
      checks++; if (cfg_and !== exp_and(1) || cfg_or !== exp_or(1)) begin errors++; $display("FAIL restart_cfg got %h/%h want %h/%h", cfg_or, cfg_and, exp_or(1), exp_and(1)); end
   endtask

   task automatic test_reset_mid_load();
      start_load();
      send_bits(0, 0, 70, 1'b0);
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      checks++; if (cfg_and !== '0 || cfg_or !== '0) begin errors++; $display("FAIL midrst_cfg got %h/%h want 0/0", cfg_or, cfg_and); end
      checks++; if (loaded !== 1'b0 || busy !== 1'b0 || bit_count !== '0 || cfg_ready !== 1'b0)
         begin errors++; $display("FAIL midrst_flags loaded=%b busy=%b count=%0d ready=%b want 0", loaded, busy, bit_count, cfg_ready); end
      cfg_valid = 1'b1;  // ignored in IDLE
      tick();
      cfg_valid = 1'b0;
      checks++; if (bit_count !== '0 || busy !== 1'b0) begin errors++; $display("FAIL idle_valid count=%0d busy=%b want 0 0", bit_count, busy); end
   endtask

   initial begin
      rst_n     = 1'b0;
      cfg_start = 1'b0;
      cfg_bit   = 1'b0;
      cfg_valid = 1'b0;
      cfg_abort = 1'b0;
      test_reset();
      test_full_load();
      test_gappy_valid();
      test_abort();
      test_restart();
      test_reset_mid_load();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
